// File: rtl/imem_responder.sv
// imem_responder: multi-cycle instruction-memory responder for the fetch stage
// Define IMEM_ALIGN_CHECK_EN to flag odd-address fetches with err instead of reading the array.
module imem_responder #(
  parameter int MEM_AW = 8,
  parameter int LATENCY = 2,
  parameter logic [15:0] NOP = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] instr,
  output logic        done,
  output logic        stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [MEM_AW:0] addr_q, rd_a;
  logic [15:0] data_q;
  logic [15:0] mem [0:(1<<MEM_AW)-1];
  logic accept;
  logic unused_bits;
  assign accept = req & (state != WAIT);
  assign rd_a = accept ? addr[MEM_AW:0] : addr_q;
  assign stall = req & (state == WAIT);
  assign done = (state == RESP) & ~flush;
  assign unused_bits = ^{addr[15:MEM_AW+1], wr_addr[15:MEM_AW+1], wr_addr[0], rd_a[0]};
  always_comb begin
    state_d = accept ? (LATENCY == 1 ? RESP : WAIT) :
              state == WAIT ? (flush ? IDLE : cnt == 4'd1 ? RESP : WAIT) : IDLE;
    cnt_d = accept ? 4'(LATENCY - 1) : (state == WAIT) & ~flush ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      addr_q <= accept ? addr[MEM_AW:0] : addr_q;
    end
  // Array is never reset; preload writes land on every edge regardless of FSM state.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr[MEM_AW:1]] <= wr_data;
`ifdef IMEM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_q <= NOP;
      err_q <= 1'b0;
    end else if (state_d == RESP) begin
      data_q <= rd_a[0] ? NOP : mem[rd_a[MEM_AW:1]];
      err_q <= rd_a[0];
    end
  assign err = done & err_q;
  assign instr = done & ~err_q ? data_q : NOP;
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) data_q <= NOP;
    else if (state_d == RESP) data_q <= mem[rd_a[MEM_AW:1]];
  assign err = 1'b0;
  assign instr = done ? data_q : NOP;
`endif
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and randomized checks against a time-based reference model
module tb_imem_responder;
  localparam int AW = 8;
  localparam int LAT = 2;
  localparam logic [15:0] NOP = 16'h0800;
  logic clk = 0, rst = 0, req = 0, flush = 0, wr_en = 0;
  logic [15:0] addr = 0, wr_addr = 0, wr_data = 0;
  logic [15:0] instr;
  logic done, stall, err;
  int checks = 0, errors = 0;
  logic [15:0] mref [0:(1<<AW)-1];
  bit busy = 0;
  int rc = 0, cyc = 0;
  logic [15:0] paddr = 0, rdata = 0, last_instr = 0, old_v = 0;
  logic last_done = 0;

  imem_responder #(.MEM_AW(AW), .LATENCY(LAT), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .instr(instr), .done(done), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int widx(logic [15:0] a);
    return int'(a[AW:1]);
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, logic [15:0] a, bit f, bit w, logic [15:0] wa, logic [15:0] wd);
    bit waiting, resp, ed, acc, ae;
    @(negedge clk);
    req = r; addr = a; flush = f; wr_en = w; wr_addr = wa; wr_data = wd;
    #1;
    waiting = busy && cyc < rc;
    resp = busy && cyc == rc;
    ed = resp && !f;
`ifdef IMEM_ALIGN_CHECK_EN
    ae = ed && paddr[0];
`else
    ae = 0;
`endif
    chk("done", 16'(done), 16'(ed));
    chk("stall", 16'(stall), 16'(r && waiting));
    chk("err", 16'(err), 16'(ae));
    chk("instr", instr, ed && !ae ? rdata : NOP);
    last_done = done;
    last_instr = instr;
    @(posedge clk);
    cyc++;
    acc = r && !waiting;
    if (waiting && f) busy = 0;
    else if (resp && !acc) busy = 0;
    if (acc) begin
      busy = 1;
      paddr = a;
      rc = cyc + LAT - 1;
    end
    if (busy && rc == cyc) rdata = mref[widx(paddr)];
    if (w) mref[widx(wa)] = wd;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2;
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_stall", 16'(stall), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    @(negedge clk) rst = 1;
    for (int i = 0; i < (1 << AW); i++) step(0, 0, 0, 1, 16'(i * 2), 16'(i * 16'h0101 ^ 16'h5A3C));
    step(0, 0, 0, 1, 16'h0004, 16'hA5C3);
    step(1, 16'h0004, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_done", 16'(last_done), 16'h1);
    chk("t2_instr", last_instr, 16'hA5C3);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_after", 16'(last_done), 16'h0);
    step(0, 0, 0, 1, 16'h0000, 16'h0001);
    step(0, 0, 0, 1, 16'h0002, 16'h0002);
    step(0, 0, 0, 1, 16'h0004, 16'h0003);
    step(1, 16'h0000, 0, 0, 0, 0);
    step(1, 16'h0002, 0, 0, 0, 0);
    chk("t3_stall", 16'(stall), 16'h1);
    step(1, 16'h0002, 0, 0, 0, 0);
    chk("t3_i1", last_instr, 16'h0001);
    step(1, 16'h0004, 0, 0, 0, 0);
    step(1, 16'h0004, 0, 0, 0, 0);
    chk("t3_i2", last_instr, 16'h0002);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_i3", last_instr, 16'h0003);
    step(1, 16'h0010, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_nodone", 16'(last_done), 16'h0);
    step(1, 16'h0020, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_instr", last_instr, mref[widx(16'h0020)]);
    old_v = mref[widx(16'h0006)];
    step(1, 16'h0006, 0, 0, 0, 0);
    step(0, 0, 0, 1, 16'h0006, 16'hBEEF);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_old", last_instr, old_v);
    step(1, 16'h0006, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_new", last_instr, 16'hBEEF);
    step(1, 16'h0003, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`ifdef IMEM_ALIGN_CHECK_EN
    chk("t6_instr", last_instr, NOP);
`else
    chk("t6_instr", last_instr, mref[widx(16'h0002)]);
`endif
    step(1, 16'h0008, 0, 0, 0, 0);
    @(negedge clk);
    req = 1;
    rst = 0;
    #1;
    chk("t1_instr", instr, NOP);
    chk("t1_done", 16'(done), 16'h0);
    chk("t1_stall", 16'(stall), 16'h0);
    @(posedge clk);
    cyc++;
    busy = 0;
    @(negedge clk);
    req = 0;
    rst = 1;
    step(1, 16'h0008, 0, 0, 0, 0);
    chk("t1_idle_stall", 16'(stall), 16'h0);
    idle(3);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom));
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
